// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode 7-segment driver with per-frame snapshot.
// Define LZB_EN to enable leading-zero blanking.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int HEX_MODE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [4*DIGITS-1:0]   count_i,
    input  logic [DIGITS-1:0]     dp_i,
    output logic [7:0]            led_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [DIGITS-1:0]   dps_q, dps_d;
    logic [7:0]          led_q, led_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;
    logic [DIGITS-1:0]   blank;
    logic                tick, last;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001101;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return (HEX_MODE == 0 && n > 4'd9) ? 7'b0110000 : g;
    endfunction

    assign tick = en_i && (pre_q == PW'(PRESCALE - 1));
    assign last = (idx_q == IW'(DIGITS - 1));

`ifdef LZB_EN
    // Mask follows the snapshot, so it changes only when a new frame is captured.
    always_comb begin
        logic run;
        blank = '0;
        run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run      = run && (snap_q[4*i +: 4] == 4'h0) && !dps_q[i];
            blank[i] = run;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        dps_d   = dps_q;
        frame_d = 1'b0;
        if (en_i) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                idx_d = last ? '0 : idx_q + 1'b1;
                if (last) begin
                    snap_d  = count_i;
                    dps_d   = dp_i;
                    frame_d = 1'b1;
                end
            end
        end
        led_d = (en_i && !blank[idx_q]) ? {glyph(snap_q[4*idx_q +: 4]), ~dps_q[idx_q]} : 8'hFF;
        an_d  = (en_i && !blank[idx_q]) ? ~(DIGITS'(1) << idx_q) : '1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            dps_q   <= '0;
            led_q   <= 8'hFF;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            dps_q   <= dps_d;
            led_q   <= led_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign led_o   = led_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;
endmodule
